demux_deser: RTL and testbench
==============================

# demux_deser

Serial-to-parallel demultiplexer: the receive end of the 4:1 condition multiplexer path. A mux whose select sweeps 0,1,2,3 serialises a 4-bit input onto one wire. This block takes that wire back in and steers each valid bit into the output lane matching its slot. When all lanes are filled it presents the rebuilt word with a one-cycle strobe. It sits directly downstream of the mux and feeds word-wide consumers.

## Interface
- WIDTH, 4: number of output lanes / word width; power of two, at least 2.
- SEL_W, 2: lane index width, equal to log2(WIDTH).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit from the mux output.
- din_valid  in  1  din is meaningful this cycle.
- start  in  1  frame marker: the bit accepted this cycle belongs to lane 0.
- q  out  WIDTH  demultiplexed lane registers; lane i holds the last bit steered to slot i.
- sel  out  SEL_W  lane index the next accepted bit will be written to.
- word  out  WIDTH  last completed word; bit i = slot i.
- word_valid  out  1  one-cycle strobe; word updated this cycle.
- busy  out  1  high while in COLLECT.
- frame_err  out  1  sticky; a frame restarted with a partial word pending.

## Operation
- The FSM has two states, IDLE and COLLECT. Reset state is IDLE.
- IDLE:
  - din_valid without start is ignored; no register changes.
  - din_valid with start: q[0] <= din, sel <= 1, go to COLLECT.
  - start without din_valid: no effect.
- COLLECT, accept = din_valid:
  - On accept, q[sel] <= din and sel <= sel+1 mod WIDTH.
  - When sel == WIDTH-1 and a bit is accepted: word <= {din, q[WIDTH-2:0]}, word_valid <= 1, sel <= 0. Stay in COLLECT; streaming is continuous.
- start in COLLECT with din_valid:
  - The bit goes to lane 0 and sel <= 1.
  - If the old sel != 0, the partial word is discarded (no word_valid) and frame_err <= 1.
  - If start coincides with sel == WIDTH-1, start wins: no word completes and frame_err is set.
- start in COLLECT without din_valid: sel <= 0, state <= IDLE. frame_err <= 1 if the old sel != 0.
- din_valid low in COLLECT: hold all state; gaps of any length are allowed between bits.
- frame_err clears only on rst.
- q lanes not yet rewritten in the current frame keep their old values. word is always built from the current frame's bits only, because word is captured only after every lane has been written in this frame.
- busy = (state == COLLECT), decoded from registered state.

## Timing
- All outputs are registered except busy, which is decoded directly from the state register.
- Reset values: q=0, sel=0, word=0, word_valid=0, busy=0, frame_err=0.
- Latency:
  - A bit sampled at edge N is visible on q and sel after edge N.
  - word/word_valid update at the edge sampling the WIDTH-th bit; word_valid is high for exactly that one cycle.
- Peak throughput is one word per WIDTH cycles. word_valid pulses back-to-back every WIDTH cycles under continuous valid.
- rst asserted mid-frame clears everything immediately, without waiting for a clock. The first bit after rst deassertion needs start to be accepted.
- There is no backpressure; a word not consumed during its word_valid cycle is overwritten by the next completed word.

## Test plan
- Reset: drive rst high with clk idle -> all outputs 0 and busy 0 with no clock edge needed.
- Basic frame: mux input 4'b0011 swept sel 0..3, giving bits 1,1,0,0; start on the first bit -> one cycle after the 4th bit word=4'b0011, word_valid high for one cycle, sel=0, frame_err=0.
- Gapped stream: bits 0,1,0,1 with din_valid dropped for 3 cycles between each -> word=4'b1010 with a single word_valid pulse; sel holds during the gaps.
- Continuous streaming: frames 4'b0011 then 4'b1100 with valid always high and start only on the first bit -> word_valid at cycles 4 and 8, words 0011 then 1100.
- Restart mid-frame: after 2 bits (1,1), start with bit 0, then bits 1,1,1 -> no word_valid for the partial frame, frame_err=1 (sticky), then word=4'b1110.
- Ignored idle input: din_valid pulses without start while in IDLE -> q, sel and word unchanged, busy=0. Then assert rst during a partial frame -> q=0, sel=0, busy=0 immediately.

Source files
------------

// File: rtl/demux_deser.sv
// Serial-to-parallel demultiplexer: steers each accepted serial bit into the lane
// matching its slot and publishes the rebuilt word with a one-cycle strobe.
module demux_deser #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             busy,
  output logic             frame_err
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n, word_n;
  logic [SEL_W-1:0] sel_n;
  logic             word_valid_n, frame_err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      q          <= '0;
      sel        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      sel        <= sel_n;
      word       <= word_n;
      word_valid <= word_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  // A start always wins over word completion, so a restart on the last slot
  // discards the partial word instead of publishing it.
  always_comb begin
    state_n      = state;
    q_n          = q;
    sel_n        = sel;
    word_n       = word;
    word_valid_n = 1'b0;
    frame_err_n  = frame_err;
    case (state)
      IDLE: begin
        if (din_valid && start) begin
          q_n[0]  = din;
          sel_n   = ONE;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (start) begin
          if (sel != '0) frame_err_n = 1'b1;
          if (din_valid) begin
            q_n[0] = din;
            sel_n  = ONE;
          end else begin
            sel_n   = '0;
            state_n = IDLE;
          end
        end else if (din_valid) begin
          q_n[sel] = din;
          if (sel == LAST) begin
            word_n       = {din, q[WIDTH-2:0]};
            word_valid_n = 1'b1;
            sel_n        = '0;
          end else begin
            sel_n = sel + ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_demux_deser.sv
// Bench for demux_deser: directed scenarios then random traffic, all checked
// against a frame-level reference model built on a queue of collected bits.
module tb_demux_deser;

  localparam int WIDTH = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             clk_en = 1'b0;
  logic             rst = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] q;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             busy;
  logic             frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model: the bits gathered so far in the current frame.
  bit               m_active;
  bit               fq[$];
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_word;
  logic             m_wv;
  logic             m_ferr;

  demux_deser #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .start      (start),
    .q          (q),
    .sel        (sel),
    .word       (word),
    .word_valid (word_valid),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = clk_en ? ~clk : clk;

  task automatic modelReset();
    m_active = 1'b0;
    fq.delete();
    m_q    = '0;
    m_word = '0;
    m_wv   = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic modelStep(input bit v, input bit s, input bit d);
    m_wv = 1'b0;
    if (!m_active) begin
      if (v && s) begin
        fq.delete();
        fq.push_back(d);
        m_q[0]   = d;
        m_active = 1'b1;
      end
    end else if (s) begin
      if (fq.size() != 0) m_ferr = 1'b1;
      fq.delete();
      if (v) begin
        fq.push_back(d);
        m_q[0] = d;
      end else begin
        m_active = 1'b0;
      end
    end else if (v) begin
      m_q[fq.size()] = d;
      fq.push_back(d);
      if (fq.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) m_word[i] = fq[i];
        m_wv = 1'b1;
        fq.delete();
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [SEL_W-1:0] exp_sel;
    exp_sel = SEL_W'(fq.size());
    checks++;
    assert (q === m_q) else begin
      errors++; $error("[TB] FAIL %s q: observed %b expected %b", tag, q, m_q);
    end
    checks++;
    assert (sel === exp_sel) else begin
      errors++; $error("[TB] FAIL %s sel: observed %0d expected %0d", tag, sel, exp_sel);
    end
    checks++;
    assert (word === m_word) else begin
      errors++; $error("[TB] FAIL %s word: observed %b expected %b", tag, word, m_word);
    end
    checks++;
    assert (word_valid === m_wv) else begin
      errors++; $error("[TB] FAIL %s word_valid: observed %b expected %b", tag, word_valid, m_wv);
    end
    checks++;
    assert (busy === m_active) else begin
      errors++; $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, m_active);
    end
    checks++;
    assert (frame_err === m_ferr) else begin
      errors++; $error("[TB] FAIL %s frame_err: observed %b expected %b", tag, frame_err, m_ferr);
    end
  endtask

  task automatic checkConst(input string tag, input logic [WIDTH-1:0] observed,
                            input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++; $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then check 1 ns later.
  task automatic applyStimulus(input bit v, input bit s, input bit d, input string tag);
    din_valid = v;
    start     = s;
    din       = d;
    @(posedge clk);
    modelStep(v, s, d);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bit v, s, d;

    // Asynchronous reset with the clock stopped
    modelReset();
    #3 rst = 1'b1;
    #2;
    checkOutput("async_reset");
    checkConst("reset_word", word, 4'b0000);
    #4 rst = 1'b0;
    #2 clk_en = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset");

    // Valid bits without start are ignored in IDLE
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, "idle_ignore");
    applyStimulus(1'b0, 1'b1, 1'b1, "idle_start_novalid");
    checkConst("idle_q", q, 4'b0000);

    // Basic frame 0011
    applyStimulus(1'b1, 1'b1, 1'b1, "basic0");
    applyStimulus(1'b1, 1'b0, 1'b1, "basic1");
    applyStimulus(1'b1, 1'b0, 1'b0, "basic2");
    applyStimulus(1'b1, 1'b0, 1'b0, "basic3");
    checkConst("basic_word", word, 4'b0011);
    checkConst("basic_wv", {3'b000, word_valid}, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, "basic_after");

    // Gapped stream 0,1,0,1 -> 1010 (new frame via start at sel 0, no error)
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, b == 0, b[0], "gap_bit");
      if (b != 3)
        for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, 1'b1, "gap_idle");
    end
    checkConst("gap_word", word, 4'b1010);

    // Continuous streaming: 0011 then 1100
    applyStimulus(1'b1, 1'b1, 1'b1, "stream");
    applyStimulus(1'b1, 1'b0, 1'b1, "stream");
    applyStimulus(1'b1, 1'b0, 1'b0, "stream");
    applyStimulus(1'b1, 1'b0, 1'b0, "stream");
    checkConst("stream_word0", word, 4'b0011);
    applyStimulus(1'b1, 1'b0, 1'b0, "stream");
    applyStimulus(1'b1, 1'b0, 1'b0, "stream");
    applyStimulus(1'b1, 1'b0, 1'b1, "stream");
    applyStimulus(1'b1, 1'b0, 1'b1, "stream");
    checkConst("stream_word1", word, 4'b1100);

    // Restart mid-frame, then start colliding with the last slot
    applyStimulus(1'b1, 1'b0, 1'b1, "restart_a");
    applyStimulus(1'b1, 1'b0, 1'b1, "restart_b");
    applyStimulus(1'b1, 1'b1, 1'b0, "restart_start");
    applyStimulus(1'b1, 1'b0, 1'b1, "restart_c");
    applyStimulus(1'b1, 1'b0, 1'b1, "restart_d");
    applyStimulus(1'b1, 1'b0, 1'b1, "restart_e");
    checkConst("restart_word", word, 4'b1110);
    applyStimulus(1'b1, 1'b0, 1'b0, "late0");
    applyStimulus(1'b1, 1'b0, 1'b0, "late1");
    applyStimulus(1'b1, 1'b0, 1'b0, "late2");
    applyStimulus(1'b1, 1'b1, 1'b1, "late_start_wins");
    applyStimulus(1'b0, 1'b1, 1'b0, "start_novalid_exit");

    // Reset during a partial frame takes effect without a clock edge
    applyStimulus(1'b1, 1'b1, 1'b1, "partial0");
    applyStimulus(1'b1, 1'b0, 1'b1, "partial1");
    din_valid = 1'b0;
    start     = 1'b0;
    #1 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("mid_reset");
    checkConst("mid_reset_q", q, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, "post_reset_nostart");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      d = $urandom_range(0, 1) == 1;
      applyStimulus(v, s, d, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
